// File: rtl/span_calc_sequencer_pkg.sv
// Shared types and constants for the SPAN margin sequencer.
package span_pkg;

  localparam int DEFAULT_RESULT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN_RUN  = 3'd1,
    ST_TSC_RUN   = 3'd2,
    ST_CROSS_RUN = 3'd3,
    ST_SUM       = 3'd4
  } seq_state_t;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_SCAN        = 2'd1;
  localparam logic [1:0] ERR_TSC         = 2'd2;
  localparam logic [1:0] ERR_CROSS_ABORT = 2'd3;

endpackage

// File: rtl/span_stage_timer.sv
// Per-stage watchdog: counts cycles since the last clear and flags the
// final permitted cycle of a stage (count == TIMEOUT-1).
module span_stage_timer #(
  parameter int TMO_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  // Cycle counter; holds once the final cycle is reached so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/span_calc_sequencer.sv
// Sequences scanning-risk, intermonth (TSC) and cross-commodity engines,
// then publishes the saturated sum as the initial margin.
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | waiting for go; margin/status hold last run
// ST_SCAN_RUN  | scan engine started, waiting for scan_done
// ST_TSC_RUN   | tsc engine started, waiting for tsc_done
// ST_CROSS_RUN | cross engine started, waiting for cross_done
// ST_SUM       | one cycle: add latched results, publish margin
module span_calc_sequencer
  import span_pkg::*;
#(
  parameter int RESULT_W = DEFAULT_RESULT_W,
  parameter int TIMEOUT  = 1000,
  parameter int TMO_W    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                abort,
  output logic                scan_start,
  input  logic                scan_done,
  input  logic [RESULT_W-1:0] scan_result,
  output logic                tsc_start,
  input  logic                tsc_done,
  input  logic [RESULT_W-1:0] tsc_result,
  output logic                cross_start,
  input  logic                cross_done,
  input  logic [RESULT_W-1:0] cross_result,
  output logic                busy,
  output logic                margin_valid,
  output logic [RESULT_W-1:0] margin,
  output logic                margin_sat,
  output logic                error,
  output logic [1:0]          err_code
);

  seq_state_t state;
  seq_state_t state_next;

  logic scan_start_next;
  logic tsc_start_next;
  logic cross_start_next;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;
  logic accept_go;
  logic latch_scan;
  logic latch_tsc;
  logic latch_cross;
  logic do_sum;
  logic fail;
  logic [1:0] fail_code;

  logic [RESULT_W-1:0] scan_q;
  logic [RESULT_W-1:0] tsc_q;
  logic [RESULT_W-1:0] cross_q;
  logic [RESULT_W+1:0] sum_full;
  logic                sum_over;

  assign tmr_enable = (state == ST_SCAN_RUN) || (state == ST_TSC_RUN) ||
                      (state == ST_CROSS_RUN);

  span_stage_timer #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Next-state and control decode; abort beats done, done beats watchdog.
  always_comb begin
    state_next       = state;
    scan_start_next  = 1'b0;
    tsc_start_next   = 1'b0;
    cross_start_next = 1'b0;
    tmr_clear        = 1'b0;
    accept_go        = 1'b0;
    latch_scan       = 1'b0;
    latch_tsc        = 1'b0;
    latch_cross      = 1'b0;
    do_sum           = 1'b0;
    fail             = 1'b0;
    fail_code        = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_next      = ST_SCAN_RUN;
          scan_start_next = 1'b1;
          tmr_clear       = 1'b1;
          accept_go       = 1'b1;
        end
      end
      ST_SCAN_RUN: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_CROSS_ABORT;
        end else if (scan_done) begin
          latch_scan     = 1'b1;
          state_next     = ST_TSC_RUN;
          tsc_start_next = 1'b1;
          tmr_clear      = 1'b1;
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_SCAN;
        end
      end
      ST_TSC_RUN: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_CROSS_ABORT;
        end else if (tsc_done) begin
          latch_tsc        = 1'b1;
          state_next       = ST_CROSS_RUN;
          cross_start_next = 1'b1;
          tmr_clear        = 1'b1;
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_TSC;
        end
      end
      ST_CROSS_RUN: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_CROSS_ABORT;
        end else if (cross_done) begin
          latch_cross = 1'b1;
          state_next  = ST_SUM;
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_CROSS_ABORT;
        end
      end
      ST_SUM: begin
        if (abort) begin
          fail      = 1'b1;
          fail_code = ERR_CROSS_ABORT;
        end else begin
          do_sum     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (fail) begin
      state_next = ST_IDLE;
    end
  end

  // State register plus registered start pulses and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      scan_start  <= 1'b0;
      tsc_start   <= 1'b0;
      cross_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      scan_start  <= scan_start_next;
      tsc_start   <= tsc_start_next;
      cross_start <= cross_start_next;
      busy        <= (state_next != ST_IDLE);
    end
  end

  // Capture each engine result when its done is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q  <= '0;
      tsc_q   <= '0;
      cross_q <= '0;
    end else begin
      if (latch_scan)  scan_q  <= scan_result;
      if (latch_tsc)   tsc_q   <= tsc_result;
      if (latch_cross) cross_q <= cross_result;
    end
  end

  // Two guard bits hold the carry of a three-term sum.
  assign sum_full = {2'b00, scan_q} + {2'b00, tsc_q} + {2'b00, cross_q};
  assign sum_over = |sum_full[RESULT_W+1:RESULT_W];

  // Published margin and sticky status; margin itself only moves in SUM.
  always_ff @(posedge clk) begin
    if (reset) begin
      margin       <= '0;
      margin_valid <= 1'b0;
      margin_sat   <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else if (accept_go) begin
      margin_valid <= 1'b0;
      margin_sat   <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else if (fail) begin
      error        <= 1'b1;
      err_code     <= fail_code;
    end else if (do_sum) begin
      margin       <= sum_over ? '1 : sum_full[RESULT_W-1:0];
      margin_sat   <= sum_over;
      margin_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_span_calc_sequencer.sv
// Self-checking bench: engines modelled as fixed-delay responders, expected
// behaviour derived from per-run timeline arithmetic.
module tb_span_calc_sequencer;

  localparam int RW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          go, abort;
  logic          scan_start, tsc_start, cross_start;
  logic          scan_done, tsc_done, cross_done;
  logic [RW-1:0] scan_result, tsc_result, cross_result;
  logic          busy, margin_valid, margin_sat, error;
  logic [RW-1:0] margin;
  logic [1:0]    err_code;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] prev_margin;

  span_calc_sequencer #(.RESULT_W(RW), .TIMEOUT(TMO), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .scan_start(scan_start), .scan_done(scan_done), .scan_result(scan_result),
    .tsc_start(tsc_start), .tsc_done(tsc_done), .tsc_result(tsc_result),
    .cross_start(cross_start), .cross_done(cross_done), .cross_result(cross_result),
    .busy(busy), .margin_valid(margin_valid), .margin(margin),
    .margin_sat(margin_sat), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".scan_start"}, scan_start, 0);
    chk({tag, ".tsc_start"}, tsc_start, 0);
    chk({tag, ".cross_start"}, cross_start, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".margin_valid"}, margin_valid, 0);
    chk({tag, ".margin"}, margin, 0);
    chk({tag, ".margin_sat"}, margin_sat, 0);
    chk({tag, ".error"}, error, 0);
    chk({tag, ".err_code"}, err_code, 0);
  endtask

  // One full run. d[i] = cycles from stage start to its done (>= TMO means
  // the engine never answers in time); abort_at = cycle of abort, 0 = none.
  task automatic run_case(input string name, input int d0, input int d1, input int d2,
                          input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                          input logic [RW-1:0] r2, input int abort_at,
                          input bit stray_go, input bit stray_x);
    int d[3];
    int st[3];
    int s, e_cyc, sum, go_cyc, x_cyc, hi;
    bit complete;
    logic [1:0] code;
    logic [RW-1:0] exp_margin;
    bit exp_sat;
    d = '{d0, d1, d2};
    st = '{-1, -1, -1};
    complete = 1'b1;
    code = 2'd0;
    s = 1;
    e_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (complete) begin
        st[i] = s;
        if (d[i] > TMO - 1) begin
          complete = 1'b0;
          e_cyc = s + TMO - 1;
          code = 2'(i + 1);
        end else begin
          s = s + d[i] + 1;
        end
      end
    end
    if (complete) e_cyc = s;
    if (abort_at >= 1 && abort_at <= e_cyc) begin
      e_cyc = abort_at;
      complete = 1'b0;
      code = 2'd3;
    end
    sum = int'(r0) + int'(r1) + int'(r2);
    exp_sat = complete && (sum > 65535);
    exp_margin = !complete ? prev_margin : (sum > 65535 ? 16'hFFFF : sum[RW-1:0]);
    go_cyc = stray_go ? int'($urandom_range(1, e_cyc)) : -1;
    hi = (st[1] > 0) ? st[1] - 1 : e_cyc;
    x_cyc = stray_x ? int'($urandom_range(1, hi)) : -1;

    scan_result = r0; tsc_result = r1; cross_result = r2;
    go = 1'b1; abort = 1'b0; scan_done = 1'b0; tsc_done = 1'b0; cross_done = 1'b0;
    for (int c = 1; c <= e_cyc + 1; c++) begin
      @(negedge clk);
      go = 1'b0; abort = 1'b0; scan_done = 1'b0; tsc_done = 1'b0; cross_done = 1'b0;
      if (c <= e_cyc) begin
        chk({name, ".scan_start"}, scan_start, (c == st[0]));
        chk({name, ".tsc_start"}, tsc_start, (c == st[1]));
        chk({name, ".cross_start"}, cross_start, (c == st[2]));
        chk({name, ".busy"}, busy, 1);
        chk({name, ".run_valid"}, margin_valid, 0);
        chk({name, ".run_error"}, error, 0);
        chk({name, ".run_margin"}, margin, prev_margin);
        if (st[0] > 0 && c == st[0] + d[0]) scan_done = 1'b1;
        if (st[1] > 0 && c == st[1] + d[1]) tsc_done = 1'b1;
        if (st[2] > 0 && c == st[2] + d[2]) cross_done = 1'b1;
        if (c == x_cyc) cross_done = 1'b1;
        if (c == go_cyc) go = 1'b1;
        if (c == abort_at) abort = 1'b1;
      end else begin
        chk({name, ".end_busy"}, busy, 0);
        chk({name, ".end_starts"}, {scan_start, tsc_start, cross_start}, 0);
        chk({name, ".end_valid"}, margin_valid, complete);
        chk({name, ".end_margin"}, margin, exp_margin);
        chk({name, ".end_sat"}, margin_sat, exp_sat);
        chk({name, ".end_error"}, error, !complete);
        chk({name, ".end_err_code"}, err_code, code);
      end
    end
    if (complete) prev_margin = exp_margin;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0;
    scan_done = 1'b0; tsc_done = 1'b0; cross_done = 1'b0;
    scan_result = '0; tsc_result = '0; cross_result = '0;
    prev_margin = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_case("normal", 2, 2, 2, 16'd100, 16'd20, 16'd5, 0, 0, 0);
    run_case("saturate", 1, 0, 3, 16'hFFF0, 16'h0020, 16'h0001, 0, 0, 0);
    run_case("tsc_timeout", 1, 50, 1, 16'd1, 16'd2, 16'd3, 0, 0, 0);
    run_case("scan_boundary", TMO - 1, 1, 1, 16'd7, 16'd8, 16'd9, 0, 0, 0);
    run_case("min_latency", 0, 0, 0, 16'd1000, 16'd200, 16'd30, 0, 0, 0);
    run_case("abort_cross", 1, 1, 3, 16'd11, 16'd22, 16'd33, 8, 0, 0);
    run_case("stray_go", 2, 3, 1, 16'd40, 16'd50, 16'd60, 0, 1, 0);
    run_case("stray_cross", 4, 1, 1, 16'd70, 16'd80, 16'd90, 0, 0, 1);
    run_case("cross_timeout", 0, 0, 50, 16'd5, 16'd5, 16'd5, 0, 0, 0);
    run_case("scan_timeout", 50, 0, 0, 16'd5, 16'd5, 16'd5, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int ab;
      logic [RW-1:0] a, b, c;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      a = RW'($urandom_range(0, 65535));
      b = RW'($urandom_range(0, 65535));
      c = RW'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 0) begin
        a = a >> 2; b = b >> 2; c = c >> 2;
      end
      run_case("random", int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), a, b, c, ab,
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of TSC_RUN after a run has left a nonzero margin.
    run_case("pre_reset", 0, 0, 0, 16'd3, 16'd4, 16'd5, 0, 0, 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    scan_done = 1'b1;
    @(negedge clk);
    scan_done = 1'b0;
    chk("mid.tsc_start", tsc_start, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    prev_margin = '0;
    @(negedge clk);
    run_case("post_reset", 1, 1, 1, 16'd10, 16'd10, 16'd10, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/span_calc_sequencer.md
Name: span_calc_sequencer

Overview:
- Sequences the three SPAN margin engines in a fixed order: scanning risk, then intermonth spread (TSC), then cross-commodity credit.
- Each engine gets a one-cycle start pulse; the sequencer then waits for that engine's done, with a per-stage watchdog.
- Once all three results are captured, it forms the saturated initial margin and publishes it with a valid flag.
- Sits between the host register file (which issues go/abort and reads margin/status) and the engine instances.

Parameters:
- RESULT_W, 16, width of each engine result and of margin.
- TIMEOUT, 1000, maximum cycles a stage may run before it is declared hung (≥2).
- TMO_W, 10, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go  in  1  single-cycle request to start a full margin calculation
- abort  in  1  cancel the calculation in progress
- scan_start  out  1  one-cycle start pulse to the scanning-risk engine
- scan_done  in  1  scanning-risk result valid (pulse)
- scan_result  in  RESULT_W  scanning risk
- tsc_start  out  1  start pulse to the intermonth engine
- tsc_done  in  1  intermonth result valid
- tsc_result  in  RESULT_W  intermonth spread charge
- cross_start  out  1  start pulse to the cross-commodity engine
- cross_done  in  1  cross result valid
- cross_result  in  RESULT_W  cross-commodity charge
- busy  out  1  high in any state other than IDLE
- margin_valid  out  1  margin holds a completed result
- margin  out  RESULT_W  scan + tsc + cross, saturated
- margin_sat  out  1  the last sum saturated
- error  out  1  last run ended by timeout or abort (sticky)
- err_code  out  2  0 none, 1 scan timeout, 2 tsc timeout, 3 cross timeout or abort

Behaviour:
- Reset dominates all other inputs, including mid-run.
  - State → IDLE.
  - All outputs and the captured results → 0.
- All outputs are registered.
- States: IDLE, SCAN_RUN, TSC_RUN, CROSS_RUN, SUM.
- IDLE:
  - go=1 → SCAN_RUN, with scan_start high for exactly the first cycle of SCAN_RUN.
  - On that go: margin_valid, margin_sat, error and err_code clear to 0; the watchdog resets to 0.
  - abort has no effect in IDLE.
- X_RUN (X = scan, tsc, cross):
  - x_done is accepted in any cycle of that state, including the start cycle.
  - On acceptance: latch x_result and advance. SCAN_RUN→TSC_RUN with tsc_start pulsed in its first cycle; TSC_RUN→CROSS_RUN with cross_start pulsed; CROSS_RUN→SUM.
  - A done belonging to any other stage is ignored.
- Watchdog:
  - Counts cycles spent in the current RUN state, starting at 0 in the start cycle.
  - If no done has been seen when the count reaches TIMEOUT-1: → IDLE, error=1, err_code = stage code.
  - A done arriving in that same final cycle wins; the stage completes normally.
- abort in any RUN state or SUM: → IDLE next edge, error=1, err_code=3, margin_valid stays 0. Abort has priority over a done in the same cycle.
- SUM (one cycle):
  - Compute a RESULT_W+2-bit sum of the three latched results.
  - If the sum exceeds 2^RESULT_W−1: margin = all ones and margin_sat=1.
  - Register margin and set margin_valid=1, then → IDLE.
- go while busy is ignored and does not restart the run.
- margin holds its value until the next SUM; margin_valid drops on an accepted go.
- Latency with every done at start+2: go seen at edge 0 → margin_valid high from cycle 11. Minimum latency, every done in its start cycle: 5 cycles.

Decomposition:
- Package span_pkg holds:
  - typedef seq_state_t (the enum of states);
  - constants ERR_NONE, ERR_SCAN, ERR_TSC, ERR_CROSS_ABORT;
  - the default RESULT_W.
- One sub-module: span_stage_timer (TMO_W-bit counter with clear, enable and expired output), instantiated once and cleared on every stage entry.

Test Plan:
- Normal run: go at cycle 0; each engine responds 2 cycles after its start with results 100, 20, 5.
  - Starts appear at cycles 1, 4, 7.
  - margin=125, margin_valid=1 at cycle 11, margin_sat=0, busy low at cycle 11.
- Saturation: results 0xFFF0, 0x0020, 0x0001 → margin=0xFFFF, margin_sat=1, margin_valid=1.
- Timeout: tsc_done never asserted, TIMEOUT=8.
  - Return to IDLE after 8 TSC_RUN cycles, error=1, err_code=2, margin_valid=0.
  - The next go clears error.
- Timeout boundary: scan_done asserted in the 8th SCAN_RUN cycle (TIMEOUT=8) → no error; tsc_start is pulsed.
- Abort in CROSS_RUN, same cycle as cross_done → IDLE, err_code=3, margin unchanged from the prior run.
- Stray inputs:
  - go asserted while busy: no extra start pulses, and the run completes normally.
  - cross_done pulsed during SCAN_RUN: ignored.
  - reset asserted mid-TSC_RUN: all outputs 0 the next cycle.
